// File: rtl/pump_sram_ctrl.sv
// Purpose: SPI-pump to SRAM loader, plus a core read port that is locked out while a load runs.
// Latency: a write strobe reaches sram_we_n_o 2 cycles after detection; a read returns RD_CYCLES+1 cycles after acceptance.
// Backpressure: one pending write byte is buffered and a second strobe is dropped (overrun_o); reads wait on core_ready_o.
// The optional load checksum/count outputs are built only when PUMP_SRAM_CHECKSUM_EN is defined.
module pump_sram_ctrl #(
    parameter int ADDR_W    = 19,
    parameter int WE_CYCLES = 2,
    parameter int RD_CYCLES = 2
) (
    input  logic              pclk,
    input  logic              reset_n,
    input  logic              pump_active_i,
    input  logic [ADDR_W-1:0] pump_a_i,
    input  logic [7:0]        pump_d_i,
    input  logic              pump_we_n_i,
    input  logic              core_rd_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    output logic              core_ready_o,
    output logic [7:0]        core_data_o,
    output logic              core_valid_o,
    output logic              load_done_o,
    output logic              overrun_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [7:0]        sram_dq_o,
    output logic              sram_dq_oe_o,
    input  logic [7:0]        sram_dq_i,
    output logic              sram_we_n_o,
`ifdef PUMP_SRAM_CHECKSUM_EN
    output logic [15:0]       load_sum_o,
    output logic [ADDR_W:0]   load_count_o,
`endif
    output logic              sram_oe_n_o
);

    typedef enum logic [2:0] {
        IDLE,
        WSETUP,
        WPULSE,
        WHOLD,
        RPULSE,
        RDONE
    } state_t;

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;

    logic              we_s1, we_s2, we_s3;
    logic              act_s1, act_s2, act_s3;
    logic              wr_det, act_rise, act_fall;

    logic              pending;
    logic [ADDR_W-1:0] pend_a;
    logic [7:0]        pend_d;
    logic              wr_take;
    logic [ADDR_W-1:0] wr_a;
    logic [7:0]        wr_d;

    logic              ld_wr, ld_rd, rd_sample;
    logic              done_armed;

    // Two-flop synchronisers plus one edge-detect flop for the sck-domain strobes
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            we_s1  <= 1'b1;
            we_s2  <= 1'b1;
            we_s3  <= 1'b1;
            act_s1 <= 1'b0;
            act_s2 <= 1'b0;
            act_s3 <= 1'b0;
        end else begin
            we_s1  <= pump_we_n_i;
            we_s2  <= we_s1;
            we_s3  <= we_s2;
            act_s1 <= pump_active_i;
            act_s2 <= act_s1;
            act_s3 <= act_s2;
        end
    end

    assign wr_det   = !we_s2 && we_s3;
    assign act_rise = act_s2 && !act_s3;
    assign act_fall = !act_s2 && act_s3;

    // A strobe is only taken when the one-deep buffer is free; pump address/data
    // are long stable by the time the synchronised strobe arrives.
    assign wr_take = wr_det && !pending;
    assign wr_a    = pending ? pend_a : pump_a_i;
    assign wr_d    = pending ? pend_d : pump_d_i;

    // A strobe seen in the same cycle as an idle slot still wins over the read
    assign core_ready_o = (state == IDLE) && !pending && !act_s2 && !wr_det;
    assign core_valid_o = (state == RDONE);
    assign load_done_o  = (done_armed || act_fall) && (state == IDLE) && !pending && !wr_det;

    // Next-state and load strobes; writes have priority over reads
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        ld_wr     = 1'b0;
        ld_rd     = 1'b0;
        rd_sample = 1'b0;
        case (state)
            IDLE: begin
                if (pending || wr_take) begin
                    state_nx = WSETUP;
                    ld_wr    = 1'b1;
                end else if (core_rd_i && core_ready_o) begin
                    state_nx = RPULSE;
                    cnt_nx   = 4'(RD_CYCLES - 1);
                    ld_rd    = 1'b1;
                end
            end
            WSETUP: begin
                state_nx = WPULSE;
                cnt_nx   = 4'(WE_CYCLES - 1);
            end
            WPULSE: begin
                if (cnt == 4'd0) state_nx = WHOLD;
                else             cnt_nx   = cnt - 4'd1;
            end
            WHOLD:  state_nx = IDLE;
            RPULSE: begin
                if (cnt == 4'd0) begin
                    state_nx  = RDONE;
                    rd_sample = 1'b1;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            RDONE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register and pulse-length counter
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // One-deep write buffer; a strobe arriving while it is full is dropped
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b0;
            pend_a  <= '0;
            pend_d  <= 8'h00;
        end else if (ld_wr) begin
            pending <= 1'b0;
        end else if (wr_take) begin
            pending <= 1'b1;
            pend_a  <= pump_a_i;
            pend_d  <= pump_d_i;
        end
    end

    // Sticky overrun flag, cleared when a new load starts
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n)                overrun_o <= 1'b0;
        else if (wr_det && pending)  overrun_o <= 1'b1;
        else if (act_rise)           overrun_o <= 1'b0;
    end

    // Load-done arms on the end of a load and fires once the write path drains
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n)         done_armed <= 1'b0;
        else if (act_rise)    done_armed <= 1'b0;
        else if (load_done_o) done_armed <= 1'b0;
        else if (act_fall)    done_armed <= 1'b1;
    end

    // Registered SRAM pins, decoded from the next state so they are glitch-free
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            sram_we_n_o  <= 1'b1;
            sram_oe_n_o  <= 1'b1;
            sram_dq_oe_o <= 1'b0;
            sram_addr_o  <= '0;
            sram_dq_o    <= 8'h00;
        end else begin
            sram_we_n_o  <= (state_nx != WPULSE);
            sram_oe_n_o  <= (state_nx != RPULSE);
            sram_dq_oe_o <= (state_nx == WSETUP) || (state_nx == WPULSE) || (state_nx == WHOLD);
            if (ld_wr) begin
                sram_addr_o <= wr_a;
                sram_dq_o   <= wr_d;
            end else if (ld_rd) begin
                sram_addr_o <= core_addr_i;
            end
        end
    end

    // Read data captured on the last output-enable cycle
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n)       core_data_o <= 8'h00;
        else if (rd_sample) core_data_o <= sram_dq_i;
    end

`ifdef PUMP_SRAM_CHECKSUM_EN
    // Running byte sum and count of completed writes for the current load
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            load_sum_o   <= 16'h0000;
            load_count_o <= '0;
        end else if (act_rise) begin
            load_sum_o   <= 16'h0000;
            load_count_o <= '0;
        end else if (state == WHOLD) begin
            load_sum_o   <= load_sum_o + {8'h00, sram_dq_o};
            load_count_o <= load_count_o + (ADDR_W+1)'(1);
        end
    end
`endif

endmodule
